// File: rtl/sram_access_ctrl.sv
// rtl/sram_access_ctrl.sv - precharge/wordline/write-drive/sense sequencer for one SRAM column slice
// Optional write readback verify: define SRAM_ACCESS_CTRL_WRITE_VERIFY_EN.
module sram_access_ctrl #(
  parameter int COLS    = 8,
  parameter int ROWS    = 16,
  parameter int PRE_CYC = 2,
  parameter int WR_CYC  = 3,
  parameter int SA_CYC  = 2,
  localparam int AW     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [AW-1:0]   req_addr,
  input  logic [COLS-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [COLS-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic            pre_en,
  output logic            wl_en,
  output logic [AW-1:0]   wl_addr,
  output logic            wd_en,
  output logic [COLS-1:0] wd_data,
  output logic            sa_en,
  input  logic [COLS-1:0] sa_out
);

  localparam int MAX_AB = (PRE_CYC > WR_CYC) ? PRE_CYC : WR_CYC;
  localparam int MAXC   = (MAX_AB > SA_CYC) ? MAX_AB : SA_CYC;
  localparam int CW     = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [AW:0] ROWS_L = (AW+1)'(ROWS);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_WR, S_RD_WL, S_RD_SA, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q;
  logic            accept, addr_bad, cnt_last;

  logic            pre_en_d, wl_en_d, wd_en_d, sa_en_d;
  logic            req_ready_d, rsp_valid_d, rsp_err_d;
  logic [COLS-1:0] rsp_rdata_d;

  assign accept   = (state_q == S_IDLE) && req_valid;
  assign addr_bad = ({1'b0, req_addr} >= ROWS_L);
  assign cnt_last = (cnt_q == '0);

  // State register plus every registered output; the async clear drops enables at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      wl_addr   <= '0;
      wd_data   <= '0;
      pre_en    <= 1'b0;
      wl_en     <= 1'b0;
      wd_en     <= 1'b0;
      sa_en     <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pre_en    <= pre_en_d;
      wl_en     <= wl_en_d;
      wd_en     <= wd_en_d;
      sa_en     <= sa_en_d;
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
      if (accept) begin
        we_q    <= req_we;
        wl_addr <= req_addr;
        wd_data <= req_wdata;
      end
    end
  end

  // Shared down-counter: loaded with length-1 on entry, state exits when it reaches zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (addr_bad) begin
            state_d = S_DONE;
          end else begin
            state_d = S_PRE;
            cnt_d   = CW'(PRE_CYC - 1);
          end
        end
      end
      S_PRE: begin
        if (cnt_last) begin
          if (we_q) begin
            state_d = S_WR;
            cnt_d   = CW'(WR_CYC - 1);
          end else begin
            state_d = S_RD_WL;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_WR: begin
        if (cnt_last) begin
`ifdef SRAM_ACCESS_CTRL_WRITE_VERIFY_EN
          state_d = S_RD_WL;
`else
          state_d = S_DONE;
`endif
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RD_WL: begin
        state_d = S_RD_SA;
        cnt_d   = CW'(SA_CYC - 1);
      end
      S_RD_SA: begin
        if (cnt_last) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state so that every output comes straight off a flop.
  always_comb begin
    pre_en_d    = (state_d == S_PRE);
    wl_en_d     = (state_d == S_WR) || (state_d == S_RD_WL) || (state_d == S_RD_SA);
    wd_en_d     = (state_d == S_WR);
    sa_en_d     = (state_d == S_RD_SA);
    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_DONE);
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata;
    if (accept && addr_bad) begin
      rsp_err_d = 1'b1;
    end
    if ((state_q == S_RD_SA) && cnt_last) begin
      rsp_rdata_d = sa_out;
`ifdef SRAM_ACCESS_CTRL_WRITE_VERIFY_EN
      rsp_err_d   = we_q && (sa_out != wd_data);
`endif
    end
  end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// tb/tb_sram_access_ctrl.sv - directed self-checking bench for sram_access_ctrl
module tb_sram_access_ctrl;

  localparam int COLS = 8;
  localparam int ROWS = 12;
  localparam int AW   = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid, req_ready, req_we;
  logic [AW-1:0]   req_addr;
  logic [COLS-1:0] req_wdata;
  logic            rsp_valid, rsp_err;
  logic [COLS-1:0] rsp_rdata;
  logic            pre_en, wl_en, wd_en, sa_en;
  logic [AW-1:0]   wl_addr;
  logic [COLS-1:0] wd_data, sa_out, sa_model;

  int n_cmp = 0;
  int n_err = 0;
  int inv_bad = 0;

  logic [15:0]     m_pre, m_wl, m_wd, m_sa, m_rv, m_rdy;
  logic [AW-1:0]   a_at [16];
  logic [COLS-1:0] d_at [16];
  logic [COLS-1:0] r_rdata;
  logic            r_err;

  always #5 clk = ~clk;

  // Sense model: only presents the programmed word while the sense amp is enabled.
  assign sa_out = sa_en ? sa_model : 8'hFF;

  sram_access_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .PRE_CYC(2), .WR_CYC(3), .SA_CYC(2)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .pre_en(pre_en), .wl_en(wl_en), .wl_addr(wl_addr),
    .wd_en(wd_en), .wd_data(wd_data), .sa_en(sa_en), .sa_out(sa_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Accepts one request (cycle 0) and records outputs for cycles 1..ncyc.
  task automatic run_txn(input logic we, input logic [AW-1:0] addr, input logic [COLS-1:0] wd,
                         input logic [AW-1:0] addr2, input logic [COLS-1:0] wd2,
                         input int drop_cyc, input int ncyc, input int rst_cyc);
    int guard = 0;
    logic got_rsp = 1'b0;
    m_pre = '0; m_wl = '0; m_wd = '0; m_sa = '0; m_rv = '0; m_rdy = '0;
    r_rdata = '0; r_err = 1'b0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) check("ready_timeout", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin
        req_addr = addr2; req_wdata = wd2;
      end
      if (c == drop_cyc) req_valid = 1'b0;
      @(negedge clk);
      m_pre[c] = pre_en; m_wl[c] = wl_en; m_wd[c] = wd_en;
      m_sa[c]  = sa_en;  m_rv[c] = rsp_valid; m_rdy[c] = req_ready;
      a_at[c]  = wl_addr; d_at[c] = wd_data;
      if (rsp_valid && !got_rsp) begin
        got_rsp = 1'b1; r_rdata = rsp_rdata; r_err = rsp_err;
      end
      if ((pre_en && wl_en) || (wd_en && sa_en) || (wd_en && !wl_en) || (sa_en && !wl_en))
        inv_bad++;
      if (c == rst_cyc) begin
        rst = 1'b1;
        #1;
        check("rst_wl_en", 32'(wl_en), 32'd0);
        check("rst_wd_en", 32'(wd_en), 32'd0);
        check("rst_pre_en", 32'(pre_en), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_wl_addr", 32'(wl_addr), 32'd0);
        break;
      end
    end
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; sa_model = '0;
    repeat (2) @(negedge clk);
    check("reset_ready", 32'(req_ready), 32'd1);
    check("reset_enables", {28'd0, pre_en, wl_en, wd_en, sa_en}, 32'd0);
    check("reset_rsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
    check("reset_rdata", 32'(rsp_rdata), 32'd0);
    check("reset_wl_addr", 32'(wl_addr), 32'd0);
    check("reset_wd_data", 32'(wd_data), 32'd0);
    rst = 1'b0;

`ifdef SRAM_ACCESS_CTRL_WRITE_VERIFY_EN
    sa_model = 8'h3D;
    run_txn(1'b1, 4'd4, 8'h3C, 4'd4, 8'h3C, 1, 10, 0);
    check("wv_pre", 32'(m_pre), 32'h006);
    check("wv_wl", 32'(m_wl), 32'h1F8);
    check("wv_wd", 32'(m_wd), 32'h038);
    check("wv_sa", 32'(m_sa), 32'h180);
    check("wv_rv", 32'(m_rv), 32'h200);
    check("wv_bad_rdata", 32'(r_rdata), 32'h3D);
    check("wv_bad_err", 32'(r_err), 32'd1);
    sa_model = 8'h3C;
    run_txn(1'b1, 4'd4, 8'h3C, 4'd4, 8'h3C, 1, 10, 0);
    check("wv_ok_rdata", 32'(r_rdata), 32'h3C);
    check("wv_ok_err", 32'(r_err), 32'd0);
`else
    sa_model = 8'h99;
    run_txn(1'b1, 4'd5, 8'hA5, 4'd5, 8'hA5, 1, 9, 0);
    check("wr_pre", 32'(m_pre), 32'h006);
    check("wr_wl", 32'(m_wl), 32'h038);
    check("wr_wd", 32'(m_wd), 32'h038);
    check("wr_sa", 32'(m_sa), 32'h000);
    check("wr_rv", 32'(m_rv), 32'h040);
    check("wr_rdy", 32'(m_rdy), 32'h380);
    check("wr_wl_addr", 32'(a_at[3]), 32'd5);
    check("wr_wd_data", 32'(d_at[3]), 32'hA5);
    check("wr_err", 32'(r_err), 32'd0);
    check("wr_rdata_unchanged", 32'(r_rdata), 32'h00);
`endif

    sa_model = 8'hA5;
    run_txn(1'b0, 4'd5, 8'h00, 4'd5, 8'h00, 1, 9, 0);
    check("rd_pre", 32'(m_pre), 32'h006);
    check("rd_wl", 32'(m_wl), 32'h038);
    check("rd_sa", 32'(m_sa), 32'h030);
    check("rd_wd", 32'(m_wd), 32'h000);
    check("rd_rv", 32'(m_rv), 32'h040);
    check("rd_rdata", 32'(r_rdata), 32'hA5);
    check("rd_err", 32'(r_err), 32'd0);

    sa_model = 8'h11;
    run_txn(1'b0, 4'd13, 8'h00, 4'd13, 8'h00, 1, 9, 0);
    check("bad_pre", 32'(m_pre), 32'h000);
    check("bad_wl", 32'(m_wl), 32'h000);
    check("bad_rv", 32'(m_rv), 32'h002);
    check("bad_err", 32'(r_err), 32'd1);
    check("bad_rdata_held", 32'(r_rdata), 32'hA5);
    check("bad_rdy", 32'(m_rdy), 32'h3FC);

`ifndef SRAM_ACCESS_CTRL_WRITE_VERIFY_EN
    run_txn(1'b1, 4'd3, 8'h5A, 4'd7, 8'hC3, 8, 15, 0);
    check("b2b_pre", 32'(m_pre), 32'h0306);
    check("b2b_wl", 32'(m_wl), 32'h1C38);
    check("b2b_wd", 32'(m_wd), 32'h1C38);
    check("b2b_rv", 32'(m_rv), 32'h2040);
    check("b2b_rdy", 32'(m_rdy), 32'hC080);
    check("b2b_addr1", 32'(a_at[4]), 32'd3);
    check("b2b_data1", 32'(d_at[4]), 32'h5A);
    check("b2b_addr2", 32'(a_at[10]), 32'd7);
    check("b2b_data2", 32'(d_at[10]), 32'hC3);
`endif

    run_txn(1'b1, 4'd2, 8'h77, 4'd2, 8'h77, 1, 9, 4);
    check("rst_mid_wd_before", 32'(m_wd), 32'h018);
    @(negedge clk);
    rst = 1'b0;
    sa_model = 8'h77;
    run_txn(1'b0, 4'd2, 8'h00, 4'd2, 8'h00, 1, 9, 0);
    check("post_rst_rv", 32'(m_rv), 32'h040);
    check("post_rst_rdata", 32'(r_rdata), 32'h77);
    check("post_rst_err", 32'(r_err), 32'd0);

    check("invariants", 32'(inv_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_access_ctrl.md
Name: sram_access_ctrl

Overview:
- Sequencer for one column slice of the mixed-signal SRAM macro: precharge, wordline, write driver and sense amplifier.
- Accepts one read or write request at a time over a valid/ready handshake.
- Drives digital enables to the analog array, in the order precharge -> wordline/write-drive or wordline/sense. Returns read data or write completion on a one-cycle response strobe.
- Its wd_data outputs feed the write driver's data inputs through the digital-to-real interface layer.

Parameters:
- COLS, 8, bits per word (one write-driver/sense-amp column each)
- ROWS, 16, number of wordlines; need not be a power of two
- PRE_CYC, 2, precharge cycles, >=1
- WR_CYC, 3, write-drive cycles with wordline high, >=1
- SA_CYC, 2, sense cycles with wordline and sense amp high, >=1

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept
- req_we  in  1  1=write, 0=read
- req_addr  in  $clog2(ROWS)  row address
- req_wdata  in  COLS  write data
- rsp_valid  out  1  one-cycle completion strobe
- rsp_rdata  out  COLS  read data (write: see Optional Feature)
- rsp_err  out  1  error, qualified by rsp_valid
- pre_en  out  1  bitline precharge enable
- wl_en  out  1  wordline enable
- wl_addr  out  $clog2(ROWS)  selected row
- wd_en  out  1  write driver enable
- wd_data  out  COLS  data to write driver
- sa_en  out  1  sense amplifier enable
- sa_out  in  COLS  sense amplifier result, valid while sa_en

Behaviour:
- Reset values: state IDLE, all enables 0, req_ready 1, rsp_valid 0, rsp_err 0, rsp_rdata 0, wl_addr 0, wd_data 0.
- All outputs are registered. Assertion of rst clears everything immediately, including mid-operation; enables drop without waiting for a clock.
- Handshake:
  - req_ready is 1 only in IDLE.
  - Acceptance occurs when req_valid && req_ready at a rising edge.
  - req_we, req_addr and req_wdata are captured at acceptance. wl_addr and wd_data hold those values until the next acceptance.
- States:
  - IDLE: on acceptance, go to PRE. If req_addr>=ROWS, go to DONE instead with rsp_err=1; no array activity.
  - PRE: pre_en=1 for PRE_CYC cycles, then WR if write, else RD_WL.
  - WR: wl_en=1 and wd_en=1 for WR_CYC cycles, then DONE.
  - RD_WL: wl_en=1 for 1 cycle (bitline develop), then RD_SA.
  - RD_SA: wl_en=1 and sa_en=1 for SA_CYC cycles. sa_out is sampled into rsp_rdata in the last RD_SA cycle. Then DONE.
  - DONE: rsp_valid=1 for exactly one cycle, then IDLE.
- Cycle numbering: the acceptance cycle is cycle 0.
  - Write: pre_en high cycles 1..PRE_CYC; wl_en/wd_en high cycles PRE_CYC+1..PRE_CYC+WR_CYC; rsp_valid at PRE_CYC+WR_CYC+1.
  - Read: rsp_valid at PRE_CYC+SA_CYC+2.
  - Back-to-back: a new request is accepted in the cycle after DONE at the earliest.
- Invariants:
  - pre_en and wl_en are never high in the same cycle.
  - wd_en and sa_en are never high in the same cycle.
  - wd_en and sa_en imply wl_en.
- One down-counter is shared by all timed states. Its width is sized for max(PRE_CYC,WR_CYC,SA_CYC). It loads on state entry.
- rsp_rdata:
  - Holds its value until the next read completion.
  - Is unchanged on writes (without the feature).
  - Is unchanged on address errors.
- req_valid dropping after acceptance has no effect. Inputs other than sa_out are ignored while busy.

Optional Feature:
- Macro: SRAM_ACCESS_CTRL_WRITE_VERIFY_EN.
- Defined: a write continues from WR to RD_WL -> RD_SA, reading back the same row.
  - The sampled sa_out is placed on rsp_rdata.
  - rsp_err=1 if the readback differs from the captured write data.
  - Write latency becomes PRE_CYC+WR_CYC+SA_CYC+2. There is no extra precharge before the readback.
- Undefined: a write ends after WR as described above, and rsp_err is only set by address errors.

Test Plan (COLS=8, ROWS=12, PRE_CYC=2, WR_CYC=3, SA_CYC=2):
- Reset, then write addr 5 data 0xA5 -> pre_en cycles 1-2; wl_en=wd_en=1 cycles 3-5; wl_addr=5, wd_data=0xA5; rsp_valid at cycle 6, rsp_err=0.
- Read addr 5 with sa_out driven 0xA5 during sa_en -> wl_en cycles 3-5, sa_en cycles 4-5; rsp_valid cycle 6 with rsp_rdata=0xA5.
- Read addr 13 (>=ROWS) -> no pre_en/wl_en activity; rsp_valid cycle 1 with rsp_err=1; req_ready back to 1 at cycle 2.
- Hold req_valid high for two back-to-back writes -> second accepted in the cycle after the first rsp_valid; req_ready=0 throughout the busy period; all overlap invariants hold.
- Assert rst during WR cycle 4 -> wl_en, wd_en and req_ready reach reset values immediately; a fresh read after release completes normally.
- With SRAM_ACCESS_CTRL_WRITE_VERIFY_EN: write 0x3C, sense model returns 0x3D -> rsp_valid at cycle 9, rsp_rdata=0x3D, rsp_err=1; with a matching 0x3C, rsp_err=0.
